// File: rtl/lycan_globals.sv
// Project-wide constants shared by the Lycan USB datapath blocks.
package lycan_globals;

    localparam int usb_packet_width = 32;
    localparam int num_peripherals  = 8;
    localparam int periph_addr_lsb  = 29;
    localparam int tx_route_timeout = 1024;

    typedef logic [2:0] periph_addr_t;

    // One-hot write strobe for a 3-bit peripheral address.
    function automatic logic [7:0] decoder(input periph_addr_t addr);
        decoder = 8'b1 << addr;
    endfunction

endpackage

// File: rtl/lycan_tx_router_buf.sv
// Two-entry shift buffer: slot0 is the head, pop shifts slot1 forward and a
// push lands in the first slot left free after the pop.
module lycan_tx_router_buf
    import lycan_globals::*;
#(
    parameter int WIDTH = usb_packet_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       cnt
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             pop_ok;
    logic [1:0]       keep;

    assign pop_ok = pop && (cnt != 2'd0);
    assign keep   = cnt - {1'b0, pop_ok};
    assign head   = slot0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 2'd0;
        end else begin
            cnt <= keep + {1'b0, push};
        end
    end

    // Payload needs no reset; occupancy alone says which slots are meaningful.
    always_ff @(posedge clk) begin
        if (pop_ok) begin
            slot0 <= slot1;
        end
        if (push) begin
            if (keep == 2'd0) begin
                slot0 <= din;
            end else begin
                slot1 <= din;
            end
        end
    end

endmodule

// File: rtl/lycan_tx_router.sv
// Routes each packet from the FTDI read FIFO to the single peripheral named by
// its address field, with per-target backpressure and a stall timeout drop.
module lycan_tx_router
    import lycan_globals::*;
#(
    parameter int NUM_PERIPH = num_peripherals,
    parameter int WIDTH      = usb_packet_width,
    parameter int ADDR_LSB   = periph_addr_lsb,
    parameter int TIMEOUT    = tx_route_timeout
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [WIDTH-1:0]      periph_tx_data,
    output logic [NUM_PERIPH-1:0] periph_tx_valid,
    input  logic [NUM_PERIPH-1:0] periph_tx_full,
    output logic [15:0]           drop_count,
    output logic                  drop_pulse,
    output logic                  busy
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]   cnt;
    logic         rd_pend;
    logic [15:0]  wait_cnt;
    periph_addr_t addr;
    logic [7:0]   full_ext;
    logic [7:0]   onehot;
    logic         in_range;
    logic         deliver;
    logic         bad_addr;
    logic         stalled;
    logic         timed_out;
    logic         pop;
    logic         drop;
    logic [2:0]   occ_after;

    lycan_tx_router_buf #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (rd_pend),
        .din  (fifo_dout),
        .pop  (pop),
        .head (periph_tx_data),
        .cnt  (cnt)
    );

    assign addr     = periph_tx_data[ADDR_LSB+2:ADDR_LSB];
    assign full_ext = 8'(periph_tx_full);
    assign onehot   = decoder(addr);
    assign in_range = int'(addr) < NUM_PERIPH;

    assign deliver   = (cnt != 2'd0) && in_range && !full_ext[addr];
    assign bad_addr  = (cnt != 2'd0) && !in_range;
    assign stalled   = (cnt != 2'd0) && in_range && full_ext[addr];
    assign timed_out = (TIMEOUT != 0) && stalled && (wait_cnt == TIMEOUT_LAST);
    assign pop       = deliver || bad_addr || timed_out;
    assign drop      = bad_addr || timed_out;

    // Reads are issued only when the slot is guaranteed free on arrival,
    // counting the read already in flight and this cycle's pop.
    assign occ_after  = 3'(cnt) + 3'(rd_pend) - 3'(pop);
    assign fifo_rd_en = !rst && !fifo_empty && (occ_after < 3'd2);

    assign periph_tx_valid = deliver ? onehot[NUM_PERIPH-1:0] : '0;
    assign drop_pulse      = drop;
    assign busy            = (cnt != 2'd0) || rd_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend    <= 1'b0;
            wait_cnt   <= 16'd0;
            drop_count <= 16'd0;
        end else begin
            rd_pend <= fifo_rd_en;
            if (pop || (cnt == 2'd0)) begin
                wait_cnt <= 16'd0;
            end else if (stalled) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule
